// File: rtl/alu_control_pipe.sv
// Pipelined RV32I ALU control decoder with stall/flush and illegal-op counting.
// Optional M-extension decode is enabled by defining MULDIV_DECODE_EN.
module alu_control_pipe #(
  parameter int PIPE_DEPTH = 1,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  input  logic [1:0]       ALUOp,
  input  logic [2:0]       funct3,
  input  logic             funct7_b5,
  input  logic             funct7_b0,
  input  logic             stall,
  input  logic             flush,
  output logic [3:0]       Operation,
  output logic             valid_out,
  output logic             illegal_out,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1101;
`ifdef MULDIV_DECODE_EN
  localparam logic [3:0] OP_MUL  = 4'b1010;
  localparam logic [3:0] OP_MULH = 4'b1011;
  localparam logic [3:0] OP_DIV  = 4'b1100;
  localparam logic [3:0] OP_REM  = 4'b1110;
`endif

  if (PIPE_DEPTH < 1 || PIPE_DEPTH > 4) begin : g_bad_depth
    $error("alu_control_pipe: PIPE_DEPTH must be 1..4");
  end

  logic [3:0] w_op;
  logic       w_ill;
  logic [3:0] w_rkey;

  assign w_rkey = {funct7_b5, funct3};

  always_comb begin
    w_op  = OP_ADD;
    w_ill = 1'b0;
    unique case (ALUOp)
      2'b00: begin
        unique case (funct3)
          3'b001:  w_op = OP_SLL;
          3'b101:  w_op = funct7_b5 ? OP_SRA : OP_SRL;
          default: w_op = OP_ADD;
        endcase
      end
      2'b01: begin
        unique case (funct3[2:1])
          2'b00:   w_op = OP_SUB;
          2'b10:   w_op = OP_SLT;
          2'b11:   w_op = OP_SLTU;
          default: w_ill = 1'b1;
        endcase
      end
      2'b10: begin
        if (funct7_b0) begin
`ifdef MULDIV_DECODE_EN
          if (funct7_b5) begin
            w_ill = 1'b1;
          end else begin
            unique case (funct3)
              3'b000:  w_op = OP_MUL;
              3'b001:  w_op = OP_MULH;
              3'b100:  w_op = OP_DIV;
              3'b110:  w_op = OP_REM;
              default: w_ill = 1'b1;
            endcase
          end
`else
          w_ill = 1'b1;
`endif
        end else begin
          unique case (w_rkey)
            4'b0000: w_op = OP_ADD;
            4'b1000: w_op = OP_SUB;
            4'b0111: w_op = OP_AND;
            4'b0110: w_op = OP_OR;
            4'b0100: w_op = OP_XOR;
            4'b0001: w_op = OP_SLL;
            4'b0101: w_op = OP_SRL;
            4'b1101: w_op = OP_SRA;
            4'b0010: w_op = OP_SLT;
            4'b0011: w_op = OP_SLTU;
            default: w_ill = 1'b1;
          endcase
        end
      end
      default: w_ill = 1'b1;
    endcase
  end

  logic [3:0] r_op  [PIPE_DEPTH];
  logic       r_vld [PIPE_DEPTH];
  logic       r_ill [PIPE_DEPTH];

  // Stage 0 only takes the decode when valid_in, otherwise a bubble.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      for (int k = 0; k < PIPE_DEPTH; k++) begin
        r_op[k]  <= OP_ADD;
        r_vld[k] <= 1'b0;
        r_ill[k] <= 1'b0;
      end
    end else if (!stall) begin
      r_op[0]  <= valid_in ? w_op : OP_ADD;
      r_vld[0] <= valid_in;
      r_ill[0] <= valid_in & w_ill;
      for (int k = 1; k < PIPE_DEPTH; k++) begin
        r_op[k]  <= r_op[k-1];
        r_vld[k] <= r_vld[k-1];
        r_ill[k] <= r_ill[k-1];
      end
    end
  end

  assign Operation   = r_op[PIPE_DEPTH-1];
  assign valid_out   = r_vld[PIPE_DEPTH-1];
  assign illegal_out = r_ill[PIPE_DEPTH-1];

  // An op leaves the last stage only on an unstalled edge, so it counts once.
  always_ff @(posedge clk) begin
    if (reset) begin
      illegal_cnt <= '0;
    end else if (valid_out && illegal_out && !stall &&
                 illegal_cnt != {CNT_W{1'b1}}) begin
      illegal_cnt <= illegal_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_control_pipe.sv
// Directed bench for alu_control_pipe (PIPE_DEPTH=2, CNT_W=8).
// Expected ops are given per step; a queue tracks them through the pipe.
module tb_alu_control_pipe;

  localparam int D = 2;

  logic       clk = 1'b0;
  logic       reset, valid_in, funct7_b5, funct7_b0, stall, flush;
  logic [1:0] ALUOp;
  logic [2:0] funct3;
  logic [3:0] Operation;
  logic       valid_out, illegal_out;
  logic [7:0] illegal_cnt;

  alu_control_pipe #(.PIPE_DEPTH(D), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in),
    .ALUOp(ALUOp), .funct3(funct3),
    .funct7_b5(funct7_b5), .funct7_b0(funct7_b0),
    .stall(stall), .flush(flush),
    .Operation(Operation), .valid_out(valid_out),
    .illegal_out(illegal_out), .illegal_cnt(illegal_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       v;
    logic [3:0] op;
    logic       il;
  } ent_t;

  localparam ent_t BUB = '{v: 1'b0, op: 4'b0010, il: 1'b0};

  ent_t       q[$];
  int         cnt_exp = 0;
  logic [3:0] e_op;
  logic       e_il;
  int         n_vec = 0;
  int         n_bad = 0;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bubbles();
    q.delete();
    for (int i = 0; i < D; i++) q.push_back(BUB);
  endtask

  task automatic cyc();
    ent_t n;
    @(posedge clk);
    if (reset) begin
      bubbles();
      cnt_exp = 0;
    end else begin
      if (!stall && q[0].v && q[0].il && cnt_exp != 255) cnt_exp++;
      if (flush) begin
        bubbles();
      end else if (!stall) begin
        n = valid_in ? '{v: 1'b1, op: e_op, il: e_il} : BUB;
        q.push_back(n);
        void'(q.pop_front());
      end
    end
    #1;
    chk("op",  {4'h0, Operation},   {4'h0, q[0].op});
    chk("vld", {7'h0, valid_out},   {7'h0, q[0].v});
    chk("ill", {7'h0, illegal_out}, {7'h0, q[0].il});
    chk("cnt", illegal_cnt,         cnt_exp[7:0]);
  endtask

  task automatic drv(input logic [1:0] a, input logic [2:0] f3,
                     input logic b5, input logic b0,
                     input logic [3:0] op, input logic il);
    valid_in  = 1'b1;
    ALUOp     = a;
    funct3    = f3;
    funct7_b5 = b5;
    funct7_b0 = b0;
    e_op      = op;
    e_il      = il;
  endtask

  task automatic idle();
    valid_in = 1'b0;
    e_op     = 4'b0010;
    e_il     = 1'b0;
  endtask

  initial begin
    bubbles();
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    drv(2'b00, 3'b000, 1'b0, 1'b0, 4'b0010, 1'b0);
    idle();
    #2;
    cyc(); cyc();
    reset = 1'b0;
    cyc(); cyc(); cyc();

    // back-to-back R-type
    drv(2'b10, 3'b000, 1'b0, 1'b0, 4'b0010, 1'b0); cyc();
    drv(2'b10, 3'b000, 1'b1, 1'b0, 4'b0110, 1'b0); cyc();
    drv(2'b10, 3'b111, 1'b0, 1'b0, 4'b0000, 1'b0); cyc();
    drv(2'b10, 3'b110, 1'b0, 1'b0, 4'b0001, 1'b0); cyc();
    drv(2'b10, 3'b101, 1'b1, 1'b0, 4'b1101, 1'b0); cyc();
    drv(2'b10, 3'b011, 1'b0, 1'b0, 4'b1001, 1'b0); cyc();
    drv(2'b00, 3'b001, 1'b0, 1'b0, 4'b1000, 1'b0); cyc();
    drv(2'b00, 3'b010, 1'b0, 1'b0, 4'b0010, 1'b0); cyc();
    drv(2'b00, 3'b101, 1'b1, 1'b0, 4'b1101, 1'b0); cyc();
    drv(2'b01, 3'b100, 1'b0, 1'b0, 4'b0111, 1'b0); cyc();
    drv(2'b01, 3'b111, 1'b0, 1'b0, 4'b1001, 1'b0); cyc();
    drv(2'b01, 3'b010, 1'b0, 1'b0, 4'b0010, 1'b1); cyc();
    drv(2'b10, 3'b001, 1'b1, 1'b0, 4'b0010, 1'b1); cyc();
`ifdef MULDIV_DECODE_EN
    drv(2'b10, 3'b000, 1'b0, 1'b1, 4'b1010, 1'b0); cyc();
    drv(2'b10, 3'b100, 1'b0, 1'b1, 4'b1100, 1'b0); cyc();
`else
    drv(2'b10, 3'b000, 1'b0, 1'b1, 4'b0010, 1'b1); cyc();
    drv(2'b10, 3'b100, 1'b0, 1'b1, 4'b0010, 1'b1); cyc();
`endif
    drv(2'b00, 3'b000, 1'b0, 1'b1, 4'b0010, 1'b0); cyc();
    idle(); cyc(); cyc();
    chk("cnt_after_decode", illegal_cnt, 8'd4);

    // stall freezes SUB at the output, flush+stall bubbles it
    drv(2'b01, 3'b000, 1'b0, 1'b0, 4'b0110, 1'b0); cyc();
    idle(); cyc();
    stall = 1'b1;
    cyc(); cyc(); cyc();
    chk("frozen_op", {4'h0, Operation}, 8'h06);
    flush = 1'b1;
    cyc();
    chk("flush_vld", {7'h0, valid_out}, 8'h00);
    stall = 1'b0; flush = 1'b0;
    cyc();

    // stalled illegal op counted once
    reset = 1'b1; cyc(); reset = 1'b0;
    drv(2'b11, 3'b000, 1'b0, 1'b0, 4'b0010, 1'b1); cyc();
    idle(); cyc();
    stall = 1'b1;
    cyc(); cyc(); cyc();
    stall = 1'b0;
    cyc(); cyc();
    chk("stall_cnt_once", illegal_cnt, 8'd1);

    // saturation
    drv(2'b11, 3'b101, 1'b0, 1'b0, 4'b0010, 1'b1);
    for (int i = 0; i < 300; i++) cyc();
    chk("sat_cnt", illegal_cnt, 8'd255);

    // reset mid-stream
    reset = 1'b1; cyc();
    reset = 1'b0; idle(); cyc();
    chk("reset_cnt", illegal_cnt, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
